// File: rtl/stb_arb_pkg.sv
`default_nettype none
// ==========================================================================
// stb_arb_pkg : shared types for the store-buffer / LSU dcache arbiter
// rev 1.0
// ==========================================================================
package stb_arb_pkg;

   localparam int ARB_ADDR_WIDTH     = 32;
   localparam int ARB_DATA_WIDTH     = 32;
   localparam int ARB_BYTE_SEL_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_BUSY = 2'd1,
      ST_BUSY = 2'd2
   } arb_state_e;

   // Granted dcache payload at the default integration widths.
   typedef struct packed {
      logic [ARB_ADDR_WIDTH-1:0]     addr;
      logic [ARB_DATA_WIDTH-1:0]     wdata;
      logic [ARB_BYTE_SEL_WIDTH-1:0] sel_byte;
      logic                          w_en;
      logic                          dmem_sel;
   } dcache_req_t;

endpackage
`default_nettype wire

// File: rtl/stb_dcache_arbiter.sv
`default_nettype none
// ==========================================================================
// stb_dcache_arbiter : load-priority arbiter for the dcache port, shared by
// store-buffer drain and LSU loads, with starvation cap and fence drain. rev 1.0
// ==========================================================================
module stb_dcache_arbiter
   import stb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = 4,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,

   input  logic [ADDR_WIDTH-1:0]     stb2arb_addr,
   input  logic [DATA_WIDTH-1:0]     stb2arb_wdata,
   input  logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte,
   input  logic                      stb2arb_w_en,
   input  logic                      stb2arb_req,
   input  logic                      stb2arb_dmem_sel,
   input  logic                      stb2arb_empty,
   input  logic                      stb2arb_ld_hit,
   output logic                      arb2stb_ack,

   input  logic [ADDR_WIDTH-1:0]     lsu2arb_addr,
   input  logic [BYTE_SEL_WIDTH-1:0] lsu2arb_sel_byte,
   input  logic                      lsu2arb_req,
   input  logic                      lsu2arb_dmem_sel,
   output logic [DATA_WIDTH-1:0]     arb2lsu_rdata,
   output logic                      arb2lsu_ack,
   input  logic                      lsu2arb_fence,
   output logic                      arb2lsu_fence_done,

   output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
   output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
   output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
   output logic                      arb2dcache_w_en,
   output logic                      arb2dcache_req,
   output logic                      arb2dcache_dmem_sel,
   input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
   input  logic                      dcache2arb_ack
);

   localparam int                   CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STARVE_LIMIT);

   // Width-parameterised form of dcache_req_t.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]     addr;
      logic [DATA_WIDTH-1:0]     wdata;
      logic [BYTE_SEL_WIDTH-1:0] sel_byte;
      logic                      w_en;
      logic                      dmem_sel;
   } payload_t;

   arb_state_e           state, state_nxt;
   payload_t             payload, payload_nxt;
   logic [CNT_WIDTH-1:0] starve_cnt, starve_cnt_nxt;
   logic                 fence_pend, fence_pend_nxt;
   logic                 fence_done;
   logic                 grant_ld, grant_st;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         payload    <= '0;
         starve_cnt <= '0;
         fence_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         payload    <= payload_nxt;
         starve_cnt <= starve_cnt_nxt;
         fence_pend <= fence_pend_nxt;
      end
   end

   assign fence_done = (state == IDLE) && stb2arb_empty && fence_pend;

   always_comb begin
      state_nxt      = state;
      payload_nxt    = payload;
      starve_cnt_nxt = starve_cnt;
      grant_ld       = 1'b0;
      grant_st       = 1'b0;
      // A fence arriving while one is pending merges into it.
      fence_pend_nxt = (fence_pend | lsu2arb_fence) & ~fence_done;

      unique case (state)
         IDLE: begin
            if (fence_pend || (lsu2arb_req && stb2arb_ld_hit)) begin
               grant_st = stb2arb_req;
            end else if (lsu2arb_req && (!stb2arb_req || (starve_cnt < CNT_MAX))) begin
               grant_ld = 1'b1;
            end else begin
               grant_st = stb2arb_req;
            end

            if (grant_st || !stb2arb_req) begin
               starve_cnt_nxt = '0;
            end else if (grant_ld && (starve_cnt < CNT_MAX)) begin
               starve_cnt_nxt = starve_cnt + 1'b1;
            end

            if (grant_st) begin
               state_nxt   = ST_BUSY;
               payload_nxt = '{addr:     stb2arb_addr,
                               wdata:    stb2arb_wdata,
                               sel_byte: stb2arb_sel_byte,
                               w_en:     stb2arb_w_en,
                               dmem_sel: stb2arb_dmem_sel};
            end else if (grant_ld) begin
               state_nxt   = LD_BUSY;
               payload_nxt = '{addr:     lsu2arb_addr,
                               wdata:    '0,
                               sel_byte: lsu2arb_sel_byte,
                               w_en:     1'b0,
                               dmem_sel: lsu2arb_dmem_sel};
            end
         end
         LD_BUSY, ST_BUSY: begin
            if (dcache2arb_ack) begin
               state_nxt   = IDLE;
               payload_nxt = '0;
            end
         end
         default: begin
            state_nxt   = IDLE;
            payload_nxt = '0;
         end
      endcase
   end

   assign arb2dcache_req      = (state != IDLE);
   assign arb2dcache_addr     = payload.addr;
   assign arb2dcache_wdata    = payload.wdata;
   assign arb2dcache_sel_byte = payload.sel_byte;
   assign arb2dcache_w_en     = payload.w_en;
   assign arb2dcache_dmem_sel = payload.dmem_sel;

   assign arb2stb_ack         = dcache2arb_ack && (state == ST_BUSY);
   assign arb2lsu_ack         = dcache2arb_ack && (state == LD_BUSY);
   assign arb2lsu_rdata       = (state == LD_BUSY) ? dcache2arb_rdata : '0;
   assign arb2lsu_fence_done  = fence_done;

endmodule
`default_nettype wire

// File: tb/tb_stb_dcache_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_stb_dcache_arbiter : randomized + directed bench with a transaction-level
// reference model of the dcache arbiter. rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_stb_dcache_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int SW    = 4;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] stb2arb_addr;
   logic [DW-1:0] stb2arb_wdata;
   logic [SW-1:0] stb2arb_sel_byte;
   logic          stb2arb_w_en, stb2arb_req, stb2arb_dmem_sel, stb2arb_empty, stb2arb_ld_hit;
   logic          arb2stb_ack;
   logic [AW-1:0] lsu2arb_addr;
   logic [SW-1:0] lsu2arb_sel_byte;
   logic          lsu2arb_req, lsu2arb_dmem_sel, lsu2arb_fence;
   logic [DW-1:0] arb2lsu_rdata;
   logic          arb2lsu_ack, arb2lsu_fence_done;
   logic [AW-1:0] arb2dcache_addr;
   logic [DW-1:0] arb2dcache_wdata;
   logic [SW-1:0] arb2dcache_sel_byte;
   logic          arb2dcache_w_en, arb2dcache_req, arb2dcache_dmem_sel;
   logic [DW-1:0] dcache2arb_rdata = '0;
   logic          dcache2arb_ack = 1'b0;

   always #5 clk = ~clk;

   stb_dcache_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .stb2arb_addr(stb2arb_addr), .stb2arb_wdata(stb2arb_wdata),
      .stb2arb_sel_byte(stb2arb_sel_byte), .stb2arb_w_en(stb2arb_w_en),
      .stb2arb_req(stb2arb_req), .stb2arb_dmem_sel(stb2arb_dmem_sel),
      .stb2arb_empty(stb2arb_empty), .stb2arb_ld_hit(stb2arb_ld_hit),
      .arb2stb_ack(arb2stb_ack),
      .lsu2arb_addr(lsu2arb_addr), .lsu2arb_sel_byte(lsu2arb_sel_byte),
      .lsu2arb_req(lsu2arb_req), .lsu2arb_dmem_sel(lsu2arb_dmem_sel),
      .arb2lsu_rdata(arb2lsu_rdata), .arb2lsu_ack(arb2lsu_ack),
      .lsu2arb_fence(lsu2arb_fence), .arb2lsu_fence_done(arb2lsu_fence_done),
      .arb2dcache_addr(arb2dcache_addr), .arb2dcache_wdata(arb2dcache_wdata),
      .arb2dcache_sel_byte(arb2dcache_sel_byte), .arb2dcache_w_en(arb2dcache_w_en),
      .arb2dcache_req(arb2dcache_req), .arb2dcache_dmem_sel(arb2dcache_dmem_sel),
      .dcache2arb_rdata(dcache2arb_rdata), .dcache2arb_ack(dcache2arb_ack)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] sel;
      logic          w_en;
      logic          dsel;
   } st_t;

   int total = 0;
   int bad   = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- environment: store buffer, LSU, dcache ----------------
   st_t           sb_q[$];
   bit            ld_active = 0, ld_repeat = 0;
   logic [AW-1:0] ld_addr = '0;
   logic [SW-1:0] ld_sel = '0;
   logic          ld_dsel = 1'b0;
   bit            auto_st = 0, auto_ld = 0, auto_fence = 0, spurious = 0;
   int            fixed_dly = 0, dly = 0, cyc = 0;
   logic [DW-1:0] last_rdata = '0;

   logic [AW-1:0] snap_addr;
   logic [DW-1:0] snap_wdata, snap_rdata;
   logic          snap_req = 1'b0, snap_wen, snap_stb_ack, snap_lsu_ack, snap_fdone, snap_dack;
   logic          snap_rst, prev_req = 1'b0;
   bit            grant_kind[$];
   logic [AW-1:0] grant_addr[$];
   int            grant_cyc[$];
   int            fence_done_cnt = 0, fence_done_cyc = -1, last_stb_ack_cyc = -1;

   function automatic logic [AW-1:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return 32'h20;
         1:       return 32'h24;
         2:       return 32'h40;
         3:       return 32'h44;
         4:       return 32'h80;
         default: return 32'h100;
      endcase
   endfunction

   function automatic int pick_dly();
      return (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
   endfunction

   task automatic push_store(logic [AW-1:0] a, logic [DW-1:0] d);
      st_t s;
      s.addr = a; s.wdata = d; s.sel = 4'hF; s.w_en = 1'b1; s.dsel = 1'b0;
      sb_q.push_back(s);
   endtask

   task automatic drive();
      stb2arb_req   = (sb_q.size() != 0);
      stb2arb_empty = (sb_q.size() == 0);
      if (sb_q.size() != 0) begin
         stb2arb_addr = sb_q[0].addr; stb2arb_wdata = sb_q[0].wdata;
         stb2arb_sel_byte = sb_q[0].sel; stb2arb_w_en = sb_q[0].w_en;
         stb2arb_dmem_sel = sb_q[0].dsel;
      end else begin
         stb2arb_addr = '0; stb2arb_wdata = '0; stb2arb_sel_byte = '0;
         stb2arb_w_en = 1'b0; stb2arb_dmem_sel = 1'b0;
      end
      lsu2arb_req = ld_active; lsu2arb_addr = ld_addr;
      lsu2arb_sel_byte = ld_sel; lsu2arb_dmem_sel = ld_dsel;
      stb2arb_ld_hit = 1'b0;
      foreach (sb_q[i]) if (sb_q[i].addr[AW-1:2] == ld_addr[AW-1:2]) stb2arb_ld_hit = 1'b1;
   endtask

   // One clock: snapshot outputs mid-cycle, then update the environment after the edge.
   task automatic step();
      @(negedge clk);
      snap_req = arb2dcache_req; snap_addr = arb2dcache_addr; snap_wdata = arb2dcache_wdata;
      snap_wen = arb2dcache_w_en; snap_stb_ack = arb2stb_ack; snap_lsu_ack = arb2lsu_ack;
      snap_fdone = arb2lsu_fence_done; snap_rdata = arb2lsu_rdata; snap_dack = dcache2arb_ack;
      snap_rst = rst_n;
      if (snap_req && !prev_req) begin
         grant_kind.push_back(snap_wen); grant_addr.push_back(snap_addr); grant_cyc.push_back(cyc);
      end
      prev_req = snap_req;
      if (snap_fdone) begin fence_done_cnt++; fence_done_cyc = cyc; end
      if (snap_stb_ack) last_stb_ack_cyc = cyc;
      cyc++;
      @(posedge clk);
      #1;
      dcache2arb_rdata = $urandom;
      if (!snap_rst) begin
         sb_q.delete(); ld_active = 0; dcache2arb_ack = 1'b0; dly = pick_dly();
      end else begin
         if (snap_stb_ack) sb_q.delete(0);
         if (snap_lsu_ack) ld_active = ld_repeat;
         if (auto_st && sb_q.size() < 4 && $urandom_range(0, 3) == 0) begin
            st_t s;
            s.addr = rand_addr(); s.wdata = $urandom; s.sel = 4'($urandom);
            s.w_en = 1'b1; s.dsel = 1'($urandom);
            sb_q.push_back(s);
         end
         if (auto_ld && !ld_active && $urandom_range(0, 2) == 0) begin
            ld_active = 1; ld_addr = rand_addr(); ld_sel = 4'($urandom); ld_dsel = 1'($urandom);
         end
         if (dcache2arb_ack) begin
            dcache2arb_ack = 1'b0; dly = pick_dly();
         end else if (arb2dcache_req) begin
            if (dly == 0) begin dcache2arb_ack = 1'b1; last_rdata = dcache2arb_rdata; end
            else dly--;
         end else if (spurious && $urandom_range(0, 9) == 0) begin
            dcache2arb_ack = 1'b1;
         end
      end
      lsu2arb_fence = auto_fence && ($urandom_range(0, 19) == 0);
      drive();
   endtask

   task automatic drain(string name);
      int n = 0;
      auto_st = 0; auto_ld = 0; auto_fence = 0; spurious = 0; ld_repeat = 0;
      while ((sb_q.size() != 0 || ld_active || snap_req || dcache2arb_ack) && n < 200) begin
         step(); n++;
      end
      check(name, 64'(n < 200), 64'd1);
      step(); step();
      grant_kind.delete(); grant_addr.delete(); grant_cyc.delete();
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   int            m_busy = 0;   // 0 none, 1 load outstanding, 2 store outstanding
   int            m_starve = 0;
   bit            m_fence = 0, m_valid = 0;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_sel;
   logic          m_wen, m_dsel;

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            check("req",        64'(arb2dcache_req), 64'(m_busy != 0));
            check("stb_ack",    64'(arb2stb_ack),    64'(dcache2arb_ack && m_busy == 2));
            check("lsu_ack",    64'(arb2lsu_ack),    64'(dcache2arb_ack && m_busy == 1));
            check("lsu_rdata",  64'(arb2lsu_rdata),  (m_busy == 1) ? 64'(dcache2arb_rdata) : 64'd0);
            check("fence_done", 64'(arb2lsu_fence_done), 64'(m_busy == 0 && stb2arb_empty && m_fence));
            if (m_busy != 0) begin
               check("dc_addr",  64'(arb2dcache_addr),     64'(m_addr));
               check("dc_wdata", 64'(arb2dcache_wdata),    64'(m_wdata));
               check("dc_sel",   64'(arb2dcache_sel_byte), 64'(m_sel));
               check("dc_wen",   64'(arb2dcache_w_en),     64'(m_wen));
               check("dc_dsel",  64'(arb2dcache_dmem_sel), 64'(m_dsel));
            end
         end
         @(posedge clk);
         if (!rst_n) begin
            m_busy = 0; m_starve = 0; m_fence = 0; m_valid = 1;
         end else if (m_valid) begin
            bit done;
            int win;
            done = (m_busy == 0) && stb2arb_empty && m_fence;
            if (m_busy == 0) begin
               if (m_fence || (lsu2arb_req && stb2arb_ld_hit)) win = stb2arb_req ? 2 : 0;
               else if (lsu2arb_req && (!stb2arb_req || m_starve < LIMIT)) win = 1;
               else win = stb2arb_req ? 2 : 0;
               if (win == 2 || !stb2arb_req) m_starve = 0;
               else if (win == 1) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
               if (win == 2) begin
                  m_addr = stb2arb_addr; m_wdata = stb2arb_wdata; m_sel = stb2arb_sel_byte;
                  m_wen = stb2arb_w_en; m_dsel = stb2arb_dmem_sel;
               end else if (win == 1) begin
                  m_addr = lsu2arb_addr; m_wdata = '0; m_sel = lsu2arb_sel_byte;
                  m_wen = 1'b0; m_dsel = lsu2arb_dmem_sel;
               end
               m_busy = win;
            end else if (dcache2arb_ack) begin
               m_busy = 0;
            end
            m_fence = (m_fence || lsu2arb_fence) && !done;
         end
      end
   end

   // ---------------- directed scenarios, then random traffic ----------------
   initial begin
      int n;
      bit exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      lsu2arb_fence = 1'b0;
      drive();
      rst_n = 1'b0;
      step();
      check("rst_req", 64'(snap_req), 64'd0);
      check("rst_addr", 64'(snap_addr), 64'd0);
      check("rst_wdata", 64'(snap_wdata), 64'd0);
      check("rst_wen", 64'(snap_wen), 64'd0);
      check("rst_acks", {snap_stb_ack, snap_lsu_ack, snap_fdone}, 64'd0);
      check("rst_rdata", 64'(snap_rdata), 64'd0);
      step();
      rst_n = 1'b1;

      // Lone store, ack after two wait cycles.
      fixed_dly = 2; dly = 2;
      push_store(32'h10, 32'hA5A5_0001);
      drive();
      step();
      check("t1_req_before_grant", 64'(snap_req), 64'd0);
      step();
      check("t1_req_granted", 64'(snap_req), 64'd1);
      check("t1_addr", 64'(snap_addr), 64'h10);
      check("t1_wdata", 64'(snap_wdata), 64'hA5A5_0001);
      check("t1_wen", 64'(snap_wen), 64'd1);
      n = 1;
      while (!snap_stb_ack && n < 20) begin step(); n++; end
      check("t1_ack_cycle", 64'(n), 64'd3);
      check("t1_ack_with_dcache", 64'(snap_dack), 64'd1);
      step();
      check("t1_req_drop", 64'(snap_req), 64'd0);
      drain("t1_drain");

      // Starvation: two stores against a continuous load stream.
      fixed_dly = 1; dly = 1; ld_repeat = 1;
      push_store(32'h40, 32'h1111_0000); push_store(32'h44, 32'h2222_0000);
      ld_active = 1; ld_addr = 32'h100; ld_sel = 4'hF; ld_dsel = 1'b1;
      drive();
      n = 0;
      while (grant_kind.size() < 10 && n < 200) begin step(); n++; end
      check("t2_timeout", 64'(grant_kind.size() >= 10), 64'd1);
      for (int i = 0; i < 10; i++)
         if (i < grant_kind.size()) check($sformatf("t2_grant%0d", i), 64'(grant_kind[i]), 64'(exp_pat[i]));
      if (grant_cyc.size() >= 2) check("t2_back_to_back", 64'(grant_cyc[1] - grant_cyc[0]), 64'd3);
      drain("t2_drain");

      // Load hitting a buffered store waits for that store.
      push_store(32'h20, 32'h0000_1234);
      ld_active = 1; ld_addr = 32'h20; ld_sel = 4'h3; ld_dsel = 1'b0;
      drive();
      n = 0;
      while (ld_active && n < 100) begin
         step(); n++;
         if (snap_lsu_ack) check("t3_rdata", 64'(snap_rdata), 64'(last_rdata));
      end
      check("t3_load_done", 64'(ld_active), 64'd0);
      if (grant_kind.size() >= 2) begin
         check("t3_first_is_store", 64'(grant_kind[0]), 64'd1);
         check("t3_then_load", 64'(grant_kind[1]), 64'd0);
         check("t3_load_addr", 64'(grant_addr[1]), 64'h20);
      end else check("t3_grants", 64'(grant_kind.size()), 64'd2);
      drain("t3_drain");

      // Fence with three buffered stores and a load queued behind it.
      fixed_dly = 0; dly = 0; fence_done_cnt = 0;
      push_store(32'h40, 32'h1); push_store(32'h44, 32'h2); push_store(32'h48, 32'h3);
      lsu2arb_fence = 1'b1;
      drive();
      step();
      ld_active = 1; ld_addr = 32'h100;
      drive();
      n = 0;
      while (grant_kind.size() < 4 && n < 100) begin step(); n++; end
      check("t4_grants", 64'(grant_kind.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         if (i < grant_kind.size()) check($sformatf("t4_kind%0d", i), 64'(grant_kind[i]), (i < 3) ? 64'd1 : 64'd0);
      check("t4_fence_once", 64'(fence_done_cnt), 64'd1);
      check("t4_fence_timing", 64'(fence_done_cyc), 64'(last_stb_ack_cyc + 1));
      drain("t4_drain");

      // Fence on an empty, idle buffer.
      fence_done_cnt = 0;
      lsu2arb_fence = 1'b1;
      drive();
      step();
      check("t5_not_yet", 64'(snap_fdone), 64'd0);
      step();
      check("t5_done", 64'(snap_fdone), 64'd1);
      step();
      check("t5_single_pulse", 64'(fence_done_cnt), 64'd1);

      // Reset while a store is outstanding.
      fixed_dly = 5; dly = 5;
      push_store(32'h80, 32'hDEAD_BEEF);
      drive();
      n = 0;
      while (!snap_req && n < 20) begin step(); n++; end
      check("t6_busy", 64'(snap_req), 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("t6_req_cleared", 64'(snap_req), 64'd0);
      check("t6_no_ack", 64'(snap_stb_ack), 64'd0);
      check("t6_payload_cleared", {snap_addr, snap_wen}, 64'd0);
      fixed_dly = 0; dly = 0;
      push_store(32'h84, 32'h5);
      drive();
      step();
      step();
      check("t6_regrant", 64'(snap_req), 64'd1);
      check("t6_regrant_addr", 64'(snap_addr), 64'h84);
      drain("t6_drain");

      // Random traffic against the model.
      fixed_dly = -1; auto_st = 1; auto_ld = 1; auto_fence = 1; spurious = 1;
      for (int i = 0; i < 4000; i++) step();
      drain("rand_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
